// File: rtl/stream_demultiplexer_1ton.sv
// rtl/stream_demultiplexer_1ton.sv - registered 1-to-N valid/ready stream demultiplexer
// Two-entry head/skid buffer steers each beat to one output port in strict arrival order.
module stream_demultiplexer_1ton #(
  parameter int WIDTH = 32,
  parameter int PORTS = 4,
  parameter int SW    = $clog2(PORTS)
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_Valid,
  input  logic [WIDTH-1:0] i_Data,
  input  logic [SW-1:0]    i_Select,
  output logic             o_Ready,
  output logic [PORTS-1:0] o_Valid,
  output logic [WIDTH-1:0] o_Data,
  input  logic [PORTS-1:0] i_Ready,
  output logic             o_Error,
  output logic [1:0]       o_Count
);

  localparam logic [SW:0] NPORTS = (SW+1)'(PORTS);

  logic [SW-1:0]    head_sel_q, head_sel_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [SW-1:0]    skid_sel_q, skid_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [1:0]       count_q, count_d;
  logic             error_q, error_d;

  logic             accept;
  logic             sel_ok;
  logic             push;
  logic             pop;
  logic [PORTS-1:0] valid_vec;

  // Ready depends only on registered occupancy, never on downstream i_Ready.
  assign o_Ready = (count_q != 2'd2);
  assign accept  = i_Valid && o_Ready;
  assign sel_ok  = ({1'b0, i_Select} < NPORTS);
  assign push    = accept && sel_ok;

  always_comb begin
    valid_vec = '0;
    for (int p = 0; p < PORTS; p++) begin
      valid_vec[p] = (count_q != 2'd0) && (head_sel_q == SW'(p));
    end
  end

  assign pop = |(valid_vec & i_Ready);

  always_comb begin
    head_sel_d  = head_sel_q;
    head_data_d = head_data_q;
    skid_sel_d  = skid_sel_q;
    skid_data_d = skid_data_q;
    count_d     = count_q;
    error_d     = accept && !sel_ok;

    if (pop) begin
      if (count_q == 2'd2) begin
        head_sel_d  = skid_sel_q;
        head_data_d = skid_data_q;
      end else if (push) begin
        head_sel_d  = i_Select;
        head_data_d = i_Data;
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_sel_d  = i_Select;
        head_data_d = i_Data;
      end else begin
        skid_sel_d  = i_Select;
        skid_data_d = i_Data;
      end
    end

    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      head_sel_q  <= '0;
      head_data_q <= '0;
      skid_sel_q  <= '0;
      skid_data_q <= '0;
      count_q     <= 2'd0;
      error_q     <= 1'b0;
    end else begin
      head_sel_q  <= head_sel_d;
      head_data_q <= head_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_data_q <= skid_data_d;
      count_q     <= count_d;
      error_q     <= error_d;
    end
  end

  assign o_Valid = valid_vec;
  assign o_Data  = head_data_q;
  assign o_Error = error_q;
  assign o_Count = count_q;

endmodule
